// File: rtl/leaf_user_out_fifo_if.sv
// Stream bundle between a user kernel output and one leaf output port.
// slave: the FIFO side; master: the kernel / leaf-interface driver side.
interface leaf_user_out_fifo_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int ADDR_BITS    = 4
);
    logic [PAYLOAD_BITS-1:0] s_din;
    logic                    s_vld;
    logic                    s_rdy;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;
    logic [ADDR_BITS:0]      fifo_count;
    logic                    almost_full;

    modport slave (
        input  s_din, s_vld, ack_interface2user,
        output s_rdy, din_leaf_user2interface, vld_user2interface,
        output fifo_count, almost_full
    );

    modport master (
        output s_din, s_vld, ack_interface2user,
        input  s_rdy, din_leaf_user2interface, vld_user2interface,
        input  fifo_count, almost_full
    );
endinterface

// File: rtl/leaf_user_out_fifo.sv
// Elastic FWFT output FIFO between a kernel stream and a leaf output port.
// Optional LEAF_OUT_STALL_CNT_EN adds a saturating stall_cycles counter.
module leaf_user_out_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_BITS    = 4,
    parameter int AF_MARGIN    = 2
) (
    input  logic                 clk_user,
    input  logic                 reset_n,
`ifdef LEAF_OUT_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    leaf_user_out_fifo_if.slave  bus
);
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AF_LVL  = (ADDR_BITS+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]      count_q, count_d;
    logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
    logic                    rdy_q;
    logic                    af_q;
    logic                    push;
    logic                    pop;

    // Handshakes, pointer/count next state and the next head word
    always_comb begin
        push     = bus.s_vld && rdy_q;
        pop      = (count_q != '0) && bus.ack_interface2user;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        dout_d = dout_q;
        if (push && count_q == '0) begin
            dout_d = bus.s_din;
        end else if (pop && push && count_q == CNT_ONE) begin
            dout_d = bus.s_din;
        end else if (pop && count_q > CNT_ONE) begin
            dout_d = mem_q[rd_ptr_q + PTR_ONE];
        end
    end

    // Control state: pointers, occupancy, registered flags and head word
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            rdy_q    <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            rdy_q    <= count_d < DEPTH_C;
            af_q     <= count_d >= AF_LVL;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk_user) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_din;
        end
    end

`ifdef LEAF_OUT_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles the head word waits for an ack, saturating
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if ((count_q != '0) && !bus.ack_interface2user
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.s_rdy                   = rdy_q;
    assign bus.vld_user2interface      = count_q != '0;
    assign bus.din_leaf_user2interface = dout_q;
    assign bus.fifo_count              = count_q;
    assign bus.almost_full             = af_q;
endmodule

// File: tb/tb_leaf_user_out_fifo.sv
// Scoreboard bench for leaf_user_out_fifo.
// Accepted words feed a queue; a negedge monitor checks head, count and flags.
module tb_leaf_user_out_fifo;
    logic clk_user = 1'b0;
    logic reset_n  = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [31:0] last_pop = '0;
    logic [31:0] q[$];

`ifdef LEAF_OUT_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    leaf_user_out_fifo_if #(.PAYLOAD_BITS(32), .ADDR_BITS(4)) bus ();

    leaf_user_out_fifo #(
        .PAYLOAD_BITS(32),
        .DEPTH(16),
        .ADDR_BITS(4),
        .AF_MARGIN(2)
    ) dut (
        .clk_user(clk_user),
        .reset_n(reset_n),
`ifdef LEAF_OUT_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .bus(bus)
    );

    always #5 clk_user = ~clk_user;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    // Monitor: compare DUT state to the model, then apply this edge's handshakes
    always @(negedge clk_user) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            chk("count", 64'(bus.fifo_count), 64'(q.size()));
            chk("vld", 64'(bus.vld_user2interface), 64'(q.size() != 0));
            chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= 14));
            if (bus.vld_user2interface && q.size() != 0) begin
                chk("head", 64'(bus.din_leaf_user2interface), 64'(q[0]));
            end
            if (bus.vld_user2interface && bus.ack_interface2user
                && q.size() != 0) begin
                last_pop = q.pop_front();
                pop_cnt++;
            end
            if (bus.s_vld && bus.s_rdy) begin
                q.push_back(bus.s_din);
                acc_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        bit acc;
        bus.s_din = '0;
        bus.s_vld = 1'b1;
        bus.ack_interface2user = 1'b0;

        // 1. reset with s_vld held high
        #12;
        chk("rst_rdy", 64'(bus.s_rdy), 64'd0);
        chk("rst_vld", 64'(bus.vld_user2interface), 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_din", 64'(bus.din_leaf_user2interface), 64'd0);
        chk("rst_af", 64'(bus.almost_full), 64'd0);
`ifdef LEAF_OUT_STALL_CNT_EN
        chk("rst_stall", 64'(stall_cycles), 64'd0);
`endif
        tick();
        reset_n = 1'b1;
        #2;
        chk("rdy_before_edge", 64'(bus.s_rdy), 64'd0);
        tick();
        chk("rdy_after_release", 64'(bus.s_rdy), 64'd1);
        chk("no_push_in_reset", 64'(bus.fifo_count), 64'd0);
        bus.s_vld = 1'b0;
        tick();

        // 2. pass-through, back-to-back
        bus.ack_interface2user = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.s_din = 32'(i);
            bus.s_vld = 1'b1;
            tick();
            chk("pt_count_le1", 64'(bus.fifo_count <= 5'd1), 64'd1);
            chk("pt_present", 64'(bus.din_leaf_user2interface), 64'(i));
        end
        bus.s_vld = 1'b0;
        tick();
        tick();
        chk("pt_pops", 64'(pop_cnt), 64'd8);
        chk("pt_last", 64'(last_pop), 64'd8);

        // 3. fill with ack low
        bus.ack_interface2user = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.s_din = 32'h100 + 32'(i);
            bus.s_vld = 1'b1;
            tick();
            chk("fill_hold", 64'(bus.din_leaf_user2interface), 64'h100);
        end
        bus.s_vld = 1'b0;
        #2;
        chk("fill_accepted", 64'(acc_cnt), 64'd16);
        chk("fill_rdy", 64'(bus.s_rdy), 64'd0);
        chk("fill_count", 64'(bus.fifo_count), 64'd16);
        chk("fill_af", 64'(bus.almost_full), 64'd1);
        tick();

        // 4. full with simultaneous ack and s_vld
        bus.ack_interface2user = 1'b1;
        bus.s_vld = 1'b1;
        bus.s_din = 32'h300;
        tick();
        chk("full_pop_only", 64'(bus.fifo_count), 64'd15);
        chk("full_rdy_back", 64'(bus.s_rdy), 64'd1);
        chk("full_new_head", 64'(bus.din_leaf_user2interface), 64'h101);
        tick();
        chk("both_count", 64'(bus.fifo_count), 64'd15);
        bus.s_vld = 1'b0;
        n = 0;
        while (bus.vld_user2interface && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(bus.vld_user2interface), 64'd0);
        chk("drain_last", 64'(last_pop), 64'h300);

        // 5. wrap with random ack and s_vld
        idx = 0;
        n = 0;
        bus.s_din = 32'h2000;
        while ((idx < 40 || q.size() != 0) && n < 3000) begin
            @(negedge clk_user);
            acc = bus.s_vld && bus.s_rdy;
            tick();
            if (acc) idx++;
            bus.s_din = 32'h2000 + 32'(idx);
            bus.s_vld = (idx < 40) && ($urandom_range(1) == 1);
            bus.ack_interface2user = $urandom_range(1) == 1;
            n++;
        end
        bus.s_vld = 1'b0;
        chk("wrap_all_pushed", 64'(idx), 64'd40);
        chk("wrap_drained", 64'(q.size()), 64'd0);
        tick();
        chk("wrap_last", 64'(last_pop), 64'h2027);

        // 6. mid-stream reset
        bus.ack_interface2user = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_din = 32'h500 + 32'(i);
            bus.s_vld = 1'b1;
            tick();
        end
        bus.s_vld = 1'b0;
        tick();
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd5);
        reset_n = 1'b0;
        #1;
        chk("mrst_vld", 64'(bus.vld_user2interface), 64'd0);
        chk("mrst_count", 64'(bus.fifo_count), 64'd0);
        chk("mrst_rdy", 64'(bus.s_rdy), 64'd0);
`ifdef LEAF_OUT_STALL_CNT_EN
        chk("mrst_stall", 64'(stall_cycles), 64'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();
        pop_cnt = 0;
        bus.ack_interface2user = 1'b1;
        bus.s_din = 32'hABCD;
        bus.s_vld = 1'b1;
        tick();
        bus.s_vld = 1'b0;
        n = 0;
        while (pop_cnt == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("mrst_first_pop", 64'(last_pop), 64'hABCD);
        chk("mrst_pop_seen", 64'(pop_cnt), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
